// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, latencies
// and the control-state record, also used by the instruction decoder.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'b0000,
    OP_MULTU = 4'b0001,
    OP_DIV   = 4'b0010,
    OP_DIVU  = 4'b0011,
    OP_MTHI  = 4'b0100,
    OP_MTLO  = 4'b0101,
    OP_MFHI  = 4'b0110,
    OP_MFLO  = 4'b0111,
    OP_NONE  = 4'b1000
  } mu_op_e;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Control state kept as one record so checkers can bind to a single signal.
  typedef struct packed {
    mdu_state_e state;
    logic [3:0] cnt;
  } mdu_ctrl_t;

  // mult, multu, div and divu are the only codes that start a busy sequence.
  function automatic logic is_start_op(input logic [3:0] op);
    return op[3:2] == 2'b00;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers. The result is
// computed at issue and held in a pending register until the latency expires.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MU_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MU_result
);

  // Issue handshake: a Start with a mult/div code is taken only on an edge
  // where busy is low; busy then stays high for the whole latency and any
  // Start or mthi/mtlo seen while busy is high is dropped, not queued.
  mdu_ctrl_t   ctrl_q;
  logic [63:0] pending_q;

  logic        accept;
  logic [63:0] pending_next;
  logic [3:0]  latency;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign accept = Start && is_start_op(MU_op) && (ctrl_q.state == ST_IDLE);

  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};

    // Divide on magnitudes so the most-negative dividend needs no special case.
    div_signed = (MU_op == OP_DIV);
    a_neg      = div_signed & A[31];
    b_neg      = div_signed & B[31];
    a_mag      = a_neg ? (~A + 32'd1) : A;
    b_mag      = (B == 32'd0) ? 32'd1 : (b_neg ? (~B + 32'd1) : B);
    q_mag      = a_mag / b_mag;
    r_mag      = a_mag % b_mag;
    quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

    pending_next = {HI, LO};
    latency      = DIV_CYCLES;
    case (MU_op)
      OP_MULT: begin
        pending_next = prod_s;
        latency      = MULT_CYCLES;
      end
      OP_MULTU: begin
        pending_next = prod_u;
        latency      = MULT_CYCLES;
      end
      OP_DIV, OP_DIVU: begin
        // A zero divisor recommits the current HI/LO, leaving them unchanged.
        if (B != 32'd0) begin
          pending_next = {rem, quot};
        end
      end
      default: begin
        pending_next = {HI, LO};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q.state <= ST_IDLE;
      ctrl_q.cnt   <= 4'd0;
      pending_q    <= 64'd0;
      busy         <= 1'b0;
      HI           <= 32'd0;
      LO           <= 32'd0;
    end else begin
      case (ctrl_q.state)
        ST_IDLE: begin
          if (accept) begin
            pending_q    <= pending_next;
            ctrl_q.cnt   <= latency;
            ctrl_q.state <= ST_RUN;
            busy         <= 1'b1;
          end else if (!Start && MU_op == OP_MTHI) begin
            HI <= A;
          end else if (!Start && MU_op == OP_MTLO) begin
            LO <= A;
          end
        end
        ST_RUN: begin
          // cnt holds the number of busy cycles left including this one.
          if (ctrl_q.cnt == 4'd1) begin
            HI           <= pending_q[63:32];
            LO           <= pending_q[31:0];
            ctrl_q.cnt   <= 4'd0;
            ctrl_q.state <= ST_IDLE;
            busy         <= 1'b0;
          end else begin
            ctrl_q.cnt <= ctrl_q.cnt - 4'd1;
          end
        end
        default: begin
          ctrl_q.state <= ST_IDLE;
          ctrl_q.cnt   <= 4'd0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    case (MU_op)
      OP_MFHI: MU_result = HI;
      OP_MFLO: MU_result = LO;
      default: MU_result = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors plus randomized
// operation sequences checked against an arithmetic reference model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MU_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MU_result;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_hi;
  logic [31:0] ref_lo;
  logic [63:0] exp_q[$];

  mult_div_unit dut (
    .clk(clk),
    .reset(reset),
    .Start(Start),
    .MU_op(MU_op),
    .A(A),
    .B(B),
    .busy(busy),
    .HI(HI),
    .LO(LO),
    .MU_result(MU_result)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: {HI, LO} after an operation, from plain arithmetic
  function automatic logic [63:0] model_op(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  return sa * sb;
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) return {hi, lo};
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // driver: caller is at a negedge; returns the number of busy cycles seen
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    Start = 1'b1;
    MU_op = op;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
    MU_op = OP_NONE;
    A     = $urandom;
    B     = $urandom;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  // driver: caller is at a negedge; one mthi/mtlo, returns at the next negedge
  task automatic write_hilo(input logic [3:0] op, input logic [31:0] a);
    Start = 1'b0;
    MU_op = op;
    A     = a;
    @(posedge clk);
    #1;
    MU_op = OP_NONE;
    A     = $urandom;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    Start = 1'b1;
    MU_op = OP_MULT;
    A     = 32'h1234_5678;
    B     = 32'h0000_0003;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo: got HI=%h LO=%h want 0/0", HI, LO);
    end
    MU_op = OP_MTHI;
    Start = 1'b0;
    @(negedge clk);
    checks++;
    if (HI !== 32'd0) begin
      errors++;
      $display("FAIL reset_mthi_priority: got HI=%h want 0", HI);
    end
    MU_op = OP_MFHI;
    #1;
    checks++;
    if (MU_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mu_result: got %h want 0", MU_result);
    end
    reset  = 1'b1;
    MU_op  = OP_NONE;
    ref_hi = 32'd0;
    ref_lo = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int n;
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, n);
    checks++;
    if (n !== 5 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_neg2x3: got busy=%0d HI=%h LO=%h want 5 ffffffff fffffffa", n, HI, LO);
    end
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    checks++;
    if (n !== 5 || HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_max: got busy=%0d HI=%h LO=%h want 5 fffffffe 00000001", n, HI, LO);
    end
    ref_hi = HI;
    ref_lo = LO;
  endtask

  task automatic test_div();
    int n;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
    checks++;
    if (n !== 10 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg7_2: got busy=%0d HI=%h LO=%h want 10 ffffffff fffffffd", n, HI, LO);
    end
    run_op(OP_DIVU, 32'd7, 32'd2, n);
    checks++;
    if (n !== 10 || HI !== 32'd1 || LO !== 32'd3) begin
      errors++;
      $display("FAIL divu_7_2: got busy=%0d HI=%h LO=%h want 10 1 3", n, HI, LO);
    end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++;
    if (n !== 10 || HI !== 32'h0 || LO !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_overflow: got busy=%0d HI=%h LO=%h want 10 0 80000000", n, HI, LO);
    end
    ref_hi = 32'h0;
    ref_lo = 32'h8000_0000;
    MU_op = OP_MFLO;
    #1;
    checks++;
    if (MU_result !== ref_lo) begin
      errors++;
      $display("FAIL mflo_after_div: got %h want %h", MU_result, ref_lo);
    end
    MU_op = OP_NONE;
  endtask

  task automatic test_div_by_zero();
    int n;
    write_hilo(OP_MTHI, 32'h0000_1234);
    write_hilo(OP_MTLO, 32'h0000_ABCD);
    checks++;
    if (HI !== 32'h1234 || LO !== 32'hABCD) begin
      errors++;
      $display("FAIL mthi_mtlo: got HI=%h LO=%h want 1234 abcd", HI, LO);
    end
    run_op(OP_DIV, 32'h0000_0064, 32'd0, n);
    checks++;
    if (n !== 10 || HI !== 32'h1234 || LO !== 32'hABCD) begin
      errors++;
      $display("FAIL div_by_zero: got busy=%0d HI=%h LO=%h want 10 1234 abcd", n, HI, LO);
    end
    ref_hi = 32'h1234;
    ref_lo = 32'hABCD;
  endtask

  task automatic test_busy_ignore();
    int n;
    logic [63:0] exp;
    exp_q.push_back(model_op(OP_MULT, 32'd5, 32'd7, ref_hi, ref_lo));
    Start = 1'b1;
    MU_op = OP_MULT;
    A     = 32'd5;
    B     = 32'd7;
    @(posedge clk);
    #1;
    Start = 1'b0;
    MU_op = OP_NONE;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      Start = 1'b0;
      MU_op = OP_NONE;
      if (c == 2) begin
        Start = 1'b1;
        MU_op = OP_DIV;
        A     = 32'd100;
        B     = 32'd3;
      end else if (c == 3) begin
        MU_op = OP_MTLO;
        A     = 32'h55;
      end else if (c == 4) begin
        MU_op = OP_MFHI;
        #1;
        checks++;
        if (MU_result !== ref_hi) begin
          errors++;
          $display("FAIL mfhi_during_run: got %h want %h", MU_result, ref_hi);
        end
      end
    end
    Start = 1'b0;
    MU_op = OP_NONE;
    exp = exp_q.pop_front();
    checks++;
    if (n !== 5 || {HI, LO} !== exp) begin
      errors++;
      $display("FAIL busy_ignore: got busy=%0d HI=%h LO=%h want 5 %h", n, HI, LO, exp);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_no_queue: got busy=%b want 0", busy);
    end
    ref_hi = exp[63:32];
    ref_lo = exp[31:0];
  endtask

  task automatic test_reset_during_run();
    int late_busy;
    write_hilo(OP_MTLO, 32'hDEAD_BEEF);
    Start = 1'b1;
    MU_op = OP_DIV;
    A     = 32'd1000;
    B     = 32'd7;
    @(posedge clk);
    #1;
    Start = 1'b0;
    MU_op = OP_NONE;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    MU_op = OP_MFLO;
    #1;
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || MU_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_in_run: got busy=%b HI=%h LO=%h mflo=%h want 0 0 0 0",
               busy, HI, LO, MU_result);
    end
    MU_op = OP_NONE;
    late_busy = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy) late_busy++;
    end
    checks++;
    if (late_busy !== 0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_in_run_no_commit: got busy_cycles=%0d HI=%h LO=%h want 0 0 0",
               late_busy, HI, LO);
    end
    ref_hi = 32'd0;
    ref_lo = 32'd0;
  endtask

  // randomized back-to-back traffic against the reference model
  task automatic test_random();
    int n;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 5));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 16));
      exp_q.push_back(model_op(op, a, b, ref_hi, ref_lo));
      if (op == OP_MTHI) exp_q[$] = {a, ref_lo};
      if (op == OP_MTLO) exp_q[$] = {ref_hi, a};
      if (op <= OP_DIVU) begin
        run_op(op, a, b, n);
        checks++;
        if (n !== ((op <= OP_MULTU) ? 5 : 10)) begin
          errors++;
          $display("FAIL rand_latency[%0d]: op=%0d got %0d", i, op, n);
        end
      end else begin
        write_hilo(op, a);
      end
      exp = exp_q.pop_front();
      checks++;
      if ({HI, LO} !== exp) begin
        errors++;
        $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h got %h%h want %h", i, op, a, b, HI, LO, exp);
      end
      ref_hi = exp[63:32];
      ref_lo = exp[31:0];
      MU_op = OP_MFHI;
      #1;
      checks++;
      if (MU_result !== ref_hi) begin
        errors++;
        $display("FAIL rand_mfhi[%0d]: got %h want %h", i, MU_result, ref_hi);
      end
      MU_op = OP_MFLO;
      #1;
      checks++;
      if (MU_result !== ref_lo) begin
        errors++;
        $display("FAIL rand_mflo[%0d]: got %h want %h", i, MU_result, ref_lo);
      end
      MU_op = OP_NONE;
    end
  endtask

  initial begin
    reset = 1'b0;
    Start = 1'b0;
    MU_op = OP_NONE;
    A     = 32'd0;
    B     = 32'd0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_busy_ignore();
    test_reset_during_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have port Start, input, 1, issue strobe for mult/multu/div/divu from decode stage.
REQ-004 SHALL have port MU_op, input, 4, operation code: 0000 mult, 0001 multu, 0010 div, 0011 divu, 0100 mthi, 0101 mtlo, 0110 mfhi, 0111 mflo, 1000 none.
REQ-005 SHALL have port A, input, 32, rs operand (dividend / multiplicand / mthi-mtlo source).
REQ-006 SHALL have port B, input, 32, rt operand (divisor / multiplier).
REQ-007 SHALL have port busy, output, 1, high while an accepted mult/div is in progress.
REQ-008 SHALL have port HI, output, 32, architectural HI register.
REQ-009 SHALL have port LO, output, 32, architectural LO register.
REQ-010 SHALL have port MU_result, output, 32, mfhi -> HI, mflo -> LO, any other op -> 0; combinational.

Function
REQ-011 States SHALL be IDLE and RUN; 4-bit down-counter cnt; 64-bit pending result register.
REQ-012 In IDLE, Start=1 with MU_op in {0000..0011} SHALL be accepted: compute pending {hi,lo}, load cnt, go RUN.
REQ-013 Latency SHALL be 5 cycles for mult/multu, 10 cycles for div/divu.
REQ-014 After acceptance at edge t0, busy SHALL be 1 for exactly N cycles (t0+1 .. t0+N); on the edge ending cycle t0+N, HI/LO SHALL take pending values and state returns to IDLE with busy=0.
REQ-015 mult: signed 32x32 -> 64, HI = [63:32], LO = [31:0]; multu: unsigned, same split.
REQ-016 div: LO = signed quotient truncated toward zero, HI = remainder with dividend's sign; divu: unsigned quotient/remainder.
REQ-017 div with A=0x80000000, B=0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-018 Divide by zero (B=0) SHALL still run 10 busy cycles and SHALL leave HI and LO unchanged.
REQ-019 Start while busy=1, or Start with MU_op outside {0000..0011}, SHALL be ignored.
REQ-020 mthi/mtlo in IDLE and busy=0 SHALL write A into HI/LO at the next edge; ignored while busy=1.
REQ-021 mthi/mtlo and Start SHALL never be honoured in the same cycle; Start takes priority.
REQ-022 MU_result for mfhi/mflo SHALL reflect HI/LO current register values, including during RUN (old values).
REQ-023 Operands A/B SHALL be captured at acceptance; later changes on A/B during RUN SHALL not affect the result.

Reset
REQ-024 reset=0 at an edge SHALL force IDLE, cnt=0, busy=0, HI=0, LO=0, pending=0.
REQ-025 Reset during RUN SHALL abort the operation with no HI/LO commit.
REQ-026 reset SHALL take priority over Start, mthi, mtlo in the same cycle.

Structure
REQ-027 MU_op codes and latency constants MULT_CYCLES=5, DIV_CYCLES=10 SHALL live in shared package mdu_pkg, also used by the decoder.
REQ-028 No sub-module is required; arithmetic SHALL be inferred operators inside mult_div_unit, counter/FSM in the same module.

Verification
REQ-029 mult A=0xFFFFFFFE(-2), B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 div A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles, LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1); divu A=7,B=2 -> LO=3, HI=1.
REQ-032 mthi 0x1234 then div with B=0 -> busy 10 cycles, HI stays 0x1234, LO stays prior value.
REQ-033 Start mult, second Start div and mtlo 0x55 issued at cycle 2 of RUN -> both ignored; only mult result commits at cycle 5.
REQ-034 Start div, reset=0 at cycle 4 -> busy=0, HI=LO=0 next cycle, no commit afterwards; mflo returns 0.
